muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage. Consumes the two

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// share one 2*XLEN accumulator; one operation in flight, start/busy/done handshake.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      wa
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state, state_nx;
   logic [2:0]          f3;
   logic [2*XLEN-1:0]   acc, acc_nx;
   logic [XLEN-1:0]     opnd;       // multiplicand or divisor magnitude
   logic [CW-1:0]       cnt;
   logic                neg_q;      // product/quotient sign flip
   logic                neg_r;      // remainder takes sign of a
   logic                last;

   // operand decode for an incoming request
   logic                sa_en, sb_en, sa, sb;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic                b_zero, ovf, special;
   logic [XLEN-1:0]     special_val;

   always_comb begin
      sa_en = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b110);
      sb_en = (funct3 == 3'b000) || (funct3 == 3'b001) ||
              (funct3 == 3'b100) || (funct3 == 3'b110);
      sa    = sa_en & a[XLEN-1];
      sb    = sb_en & b[XLEN-1];
      // -MIN_NEG wraps to itself, which reads correctly as an unsigned magnitude
      mag_a = sa ? -a : a;
      mag_b = sb ? -b : b;
      b_zero = (b == '0);
      ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      special = funct3[2] && (b_zero || ovf);
      if (b_zero) special_val = funct3[1] ? a : '1;
      else        special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // one iteration step of whichever operation is active
   logic [XLEN:0]       sum, trial;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     q_fix, r_fix, res_fix;

   always_comb begin
      sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
      if (state == MUL)
         acc_nx = {sum, acc[XLEN-1:1]};
      else if (!trial[XLEN])
         acc_nx = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_nx = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};

      prod_fix = neg_q ? -acc_nx : acc_nx;
      q_fix    = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
      r_fix    = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
      if (state == MUL)
         res_fix = (f3[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else
         res_fix = f3[1] ? r_fix : q_fix;
   end

   assign last = (cnt == CW'(XLEN-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (!start)          state_nx = IDLE;
            else if (!funct3[2]) state_nx = MUL;
            else if (special)    state_nx = DONE;
            else                 state_nx = DIV;
         end
         MUL, DIV: if (last) state_nx = DONE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f3     <= '0;
         acc    <= '0;
         opnd   <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
         wa     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  f3    <= funct3;
                  wa    <= rd_in;
                  cnt   <= '0;
                  neg_q <= sa ^ sb;
                  neg_r <= sa;
                  // multiplier / dividend sits in the low half and shifts out
                  acc   <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                  opnd  <= funct3[2] ? mag_b : mag_a;
                  if (special) result <= special_val;
               end
            end
            MUL, DIV: begin
               acc <= acc_nx;
               cnt <= cnt + CW'(1);
               if (last) result <= res_fix;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == MUL) || (state == DIV);
   assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand sequences for
// back-to-back issue, start-while-busy and mid-divide reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] a, b;
   logic [4:0]  rd_in;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  wa;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .a(a), .b(b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .wa(wa)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      logic        fast;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // issue one op and wait for done; returns at the negedge inside the DONE cycle
   task automatic run_op(input logic nowait, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] rd,
                         output int lat, output int bcnt, output logic got);
      if (!nowait) @(negedge clk);
      start = 1'b1; funct3 = f; a = x; b = y; rd_in = rd;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      got = done;
   endtask

   task automatic check_op(input string name, input vec_t v, input logic nowait);
      int lat, bcnt;
      logic got;
      run_op(nowait, v.f3, v.a, v.b, v.rd, lat, bcnt, got);
      check({name, " done seen"}, 32'(got), 32'd1);
      check({name, " result"}, result, v.exp);
      check({name, " wa"}, 32'(wa), 32'(v.rd));
      check({name, " latency"}, lat, v.fast ? 32'd1 : 32'd33);
      check({name, " busy cycles"}, bcnt, v.fast ? 32'd0 : 32'd32);
   endtask

   initial begin
      int lat, bcnt, npulse;
      logic got;

      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 1'b0};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 1'b0};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        1'b0};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         1'b0};
      vecs[8]  = '{3'b101, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{3'b111, 32'd5,         32'd0,         5'd14, 32'd5,         1'b1};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1'b1};
      vecs[12] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0};
      vecs[13] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 1'b0};
      vecs[14] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'h0000_0001, 1'b0};
      vecs[15] = '{3'b110, 32'h8000_0000, 32'h0000_0000, 5'd19, 32'h8000_0000, 1'b1};

      reset = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; rd_in = '0;
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      check("reset wa", 32'(wa), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         check_op($sformatf("vec%0d", i), vecs[i], 1'b0);
         @(negedge clk);
         check($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
         check($sformatf("vec%0d result hold", i), result, vecs[i].exp);
      end

      // back-to-back: new start issued in the DONE cycle of the previous op
      check_op("b2b first", vecs[6], 1'b0);
      check_op("b2b second", vecs[0], 1'b1);
      check_op("b2b third fast", vecs[9], 1'b1);
      check_op("b2b fourth", vecs[4], 1'b1);

      // start pulsed while MUL is running must be ignored
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; a = 32'd7; b = 32'hFFFF_FFFD; rd_in = 5'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd0; rd_in = 5'd9;
      @(negedge clk);
      start = 1'b0;
      lat = 7;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
      check("ignore start done seen", 32'(done), 32'd1);
      check("ignore start latency", lat, 32'd33);
      check("ignore start result", result, 32'hFFFF_FFEB);
      check("ignore start wa", 32'(wa), 32'd5);

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7; rd_in = 5'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre-reset busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid reset busy", 32'(busy), 32'd0);
      check("mid reset done", 32'(done), 32'd0);
      check("mid reset result", result, 32'd0);
      check("mid reset wa", 32'(wa), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      npulse = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) npulse++;
      end
      check("no activity after reset", npulse, 32'd0);
      check_op("after reset", vecs[6], 1'b0);

      run_op(1'b0, 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd31, lat, bcnt, got);
      check("mulhu 2^32 got", 32'(got), 32'd1);
      check("mulhu 2^32 result", result, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
